// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Multi-port register file with an integrated writeback scoreboard.
//   NUM_READ synchronous read ports (one cycle latency, same-cycle write
//   bypass), one write port, optional hardwired zero register, and one busy
//   bit per register. Busy is set on issue and cleared on writeback.
//
// Ports
//   Clock          : single clock, all state updates on the rising edge
//   Reset          : asynchronous, active-high; clears all state and outputs
//   Read_Register  : packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   Read_Data      : packed registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Read_Busy      : registered busy flag of each port's addressed register
//   Reg_Write      : write enable
//   Write_Register : write address
//   Write_Data     : write data
//   Issue_Valid    : mark Issue_Register as pending writeback
//   Issue_Register : destination register of the issuing instruction
//   Busy_Vector    : current busy bit per register (bit n = register n)
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] Read_Register,
    output logic [NUM_READ*DATA_WIDTH-1:0] Read_Data,
    output logic [NUM_READ-1:0]            Read_Busy,
    input  logic                           Reg_Write,
    input  logic [ADDR_WIDTH-1:0]          Write_Register,
    input  logic [DATA_WIDTH-1:0]          Write_Data,
    input  logic                           Issue_Valid,
    input  logic [ADDR_WIDTH-1:0]          Issue_Register,
    output logic [(1<<ADDR_WIDTH)-1:0]     Busy_Vector
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam bit ZERO_ON = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_nxt;

    logic                  wr_en;
    logic                  iss_en;

    logic [ADDR_WIDTH-1:0] rd_addr     [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_data_nxt [NUM_READ];
    logic                  rd_busy_nxt [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_data_q   [NUM_READ];
    logic                  rd_busy_q   [NUM_READ];

    // Accesses to a hardwired zero register are dropped before they reach
    // the array, the busy bits or the bypass path.
    always_comb begin
        wr_en  = Reg_Write;
        iss_en = Issue_Valid;
        if (ZERO_ON && (Write_Register == '0)) begin
            wr_en = 1'b0;
        end
        if (ZERO_ON && (Issue_Register == '0)) begin
            iss_en = 1'b0;
        end
    end

    // Issue is applied after writeback so that a same-cycle issue to the
    // register being written (a newer instruction) leaves it busy.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_en) begin
            busy_nxt[Write_Register] = 1'b0;
        end
        if (iss_en) begin
            busy_nxt[Issue_Register] = 1'b1;
        end
        if (ZERO_ON) begin
            busy_nxt[0] = 1'b0;
        end
    end

    genvar gp;
    generate
        for (gp = 0; gp < NUM_READ; gp++) begin : g_port
            assign rd_addr[gp] = Read_Register[gp*ADDR_WIDTH +: ADDR_WIDTH];
            assign Read_Data[gp*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[gp];
            assign Read_Busy[gp] = rd_busy_q[gp];
        end
    endgenerate

    // Read busy reports the next-state bit, so a port reading a register
    // during its writeback/issue cycle sees the post-edge scoreboard.
    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            rd_data_nxt[p] = mem[rd_addr[p]];
            rd_busy_nxt[p] = busy_nxt[rd_addr[p]];
            if (wr_en && (Write_Register == rd_addr[p])) begin
                rd_data_nxt[p] = Write_Data;
            end
            if (ZERO_ON && (rd_addr[p] == '0)) begin
                rd_data_nxt[p] = '0;
                rd_busy_nxt[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int n = 0; n < DEPTH; n++) begin
                mem[n] <= '0;
            end
        end else if (wr_en) begin
            mem[Write_Register] <= Write_Data;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int p = 0; p < NUM_READ; p++) begin
                rd_data_q[p] <= '0;
                rd_busy_q[p] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < NUM_READ; p++) begin
                rd_data_q[p] <= rd_data_nxt[p];
                rd_busy_q[p] <= rd_busy_nxt[p];
            end
        end
    end

    assign Busy_Vector = busy_q;

endmodule
